pes_pipe_adder: RTL and testbench

- Parametrised, pipelined N-bit adder/subtractor. It is the sequential successor to the single-bit half adder.
- Splits a WIDTH-bit operation into STAGES equal slices. One slice is resolved per cycle, and the carry is registered between slices.
- Valid/ready handshake on input and output; full throughput of one operation per cycle when not back-pressured.
- Used as the datapath arithmetic element wherever a timing-friendly wide add or subtract is needed.

---
 rtl/pes_adder_pkg.sv | 23 ++
 rtl/pes_adder_slice.sv | 26 ++
 rtl/pes_pipe_adder.sv | 142 ++++++++++++++
 tb/tb_pes_pipe_adder.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/pes_adder_pkg.sv
// rtl/pes_adder_pkg.sv - shared constants and slice-width helper for the pipelined adder
//
// Contents:
//   PES_ADD / PES_SUB   operation mode encodings for i_mode
//   pes_slice_width()   slice width of a WIDTH/STAGES split, 0 when the split is illegal
`timescale 1ns/1ps

package pes_adder_pkg;

   localparam logic PES_ADD = 1'b0;
   localparam logic PES_SUB = 1'b1;

   // Returns 0 for an illegal configuration so the top level can refuse to
   // elaborate instead of silently truncating slices.
   function automatic int pes_slice_width(input int width, input int stages);
      if (stages < 1 || stages > width)
         return 0;
      if ((width % stages) != 0)
         return 0;
      return width / stages;
   endfunction

endpackage

// File: rtl/pes_adder_slice.sv
// rtl/pes_adder_slice.sv - SW-bit combinational full adder, one pipeline slice
//
// Ports:
//   a, b   SW-bit operands (b already inverted for subtract)
//   cin    carry into the slice LSB
//   sum    SW-bit slice result
//   cout   carry out of the slice MSB
`timescale 1ns/1ps

module pes_adder_slice #(
   parameter int SW = 4
) (
   input  logic [SW-1:0] a,
   input  logic [SW-1:0] b,
   input  logic          cin,
   output logic [SW-1:0] sum,
   output logic          cout
);

   logic [SW:0] total;

   assign total = {1'b0, a} + {1'b0, b} + {{SW{1'b0}}, cin};
   assign sum   = total[SW-1:0];
   assign cout  = total[SW];

endmodule

// File: rtl/pes_pipe_adder.sv
// rtl/pes_pipe_adder.sv - pipelined WIDTH-bit adder/subtractor, one slice per stage
//
// Ports:
//   i_clk, i_rst_n     clock, asynchronous active-low reset
//   i_valid, o_ready   input handshake
//   i_a, i_b           WIDTH-bit operands
//   i_cin              carry-in (add mode only)
//   i_mode             PES_ADD: a+b+cin, PES_SUB: a-b
//   o_valid, i_ready   output handshake
//   o_sum              WIDTH-bit result
//   o_carry            carry out of MSB (1 = no borrow when subtracting)
//   o_ovf              two's-complement signed overflow
`timescale 1ns/1ps

module pes_pipe_adder
   import pes_adder_pkg::*;
#(
   parameter int WIDTH  = 16,
   parameter int STAGES = 4
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_valid,
   output logic             o_ready,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   input  logic             i_cin,
   input  logic             i_mode,
   output logic             o_valid,
   input  logic             i_ready,
   output logic [WIDTH-1:0] o_sum,
   output logic             o_carry,
   output logic             o_ovf
);

   localparam int SW   = pes_slice_width(WIDTH, STAGES);
   localparam int LAST = STAGES - 1;

   if (SW < 1) begin : g_bad_cfg
      $error("pes_pipe_adder: WIDTH must be a non-zero multiple of STAGES");
   end

   // Pipeline registers. Every stage carries full-width operands and a
   // full-width partial sum; slices below k are final, slices above k are
   // still operands waiting for their turn.
   logic [STAGES-1:0] v_q;
   logic [STAGES-1:0] c_q;
   logic [WIDTH-1:0]  a_q [STAGES];
   logic [WIDTH-1:0]  b_q [STAGES];
   logic [WIDTH-1:0]  s_q [STAGES];
   logic              ovf_q;

   // Per-stage combinational view: what stage k sees and what it will store.
   logic [WIDTH-1:0]  a_d  [STAGES];
   logic [WIDTH-1:0]  b_d  [STAGES];
   logic [WIDTH-1:0]  s_d  [STAGES];
   logic [WIDTH-1:0]  s_nx [STAGES];
   logic [STAGES-1:0] cin_d;
   logic [STAGES-1:0] cout_d;

   logic en;
   logic accept;
   logic ovf_nx;

   // The whole pipe moves as one; it only holds when a result is waiting
   // and the consumer is not taking it.
   assign en      = !v_q[LAST] || i_ready;
   assign accept  = i_valid && en;
   assign o_ready = en;

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      logic [SW-1:0]    slice_sum;
      logic [WIDTH-1:0] slice_mask;

      if (k == 0) begin : g_first
         // Subtract is a + ~b + 1, so the inversion happens once at entry and
         // the forced carry replaces i_cin.
         assign a_d[k]   = i_a;
         assign b_d[k]   = (i_mode == PES_SUB) ? ~i_b : i_b;
         assign cin_d[k] = (i_mode == PES_SUB) ? 1'b1 : i_cin;
         assign s_d[k]   = '0;
      end else begin : g_next
         assign a_d[k]   = a_q[k-1];
         assign b_d[k]   = b_q[k-1];
         assign cin_d[k] = c_q[k-1];
         assign s_d[k]   = s_q[k-1];
      end

      pes_adder_slice #(
         .SW (SW)
      ) u_slice (
         .a    (a_d[k][k*SW +: SW]),
         .b    (b_d[k][k*SW +: SW]),
         .cin  (cin_d[k]),
         .sum  (slice_sum),
         .cout (cout_d[k])
      );

      // Merge the new slice into the partial sum without disturbing the
      // slices already resolved by earlier stages.
      assign slice_mask = WIDTH'({SW{1'b1}}) << (k * SW);
      assign s_nx[k]    = (s_d[k] & ~slice_mask) | (WIDTH'(slice_sum) << (k * SW));
   end

   // Overflow only needs the MSB of A, effective B and the final sum, all of
   // which are visible at the last stage's inputs.
   assign ovf_nx = (a_d[LAST][WIDTH-1] == b_d[LAST][WIDTH-1]) &&
                   (s_nx[LAST][WIDTH-1] != a_d[LAST][WIDTH-1]);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         v_q   <= '0;
         c_q   <= '0;
         ovf_q <= 1'b0;
         for (int k = 0; k < STAGES; k++) begin
            a_q[k] <= '0;
            b_q[k] <= '0;
            s_q[k] <= '0;
         end
      end else if (en) begin
         v_q[0] <= accept;
         for (int k = 1; k < STAGES; k++) begin
            v_q[k] <= v_q[k-1];
         end
         // Bubbles advance through the data path too; their contents are
         // simply never qualified by a valid bit.
         for (int k = 0; k < STAGES; k++) begin
            a_q[k] <= a_d[k];
            b_q[k] <= b_d[k];
            s_q[k] <= s_nx[k];
            c_q[k] <= cout_d[k];
         end
         ovf_q <= ovf_nx;
      end
   end

   assign o_valid = v_q[LAST];
   assign o_sum   = s_q[LAST];
   assign o_carry = c_q[LAST];
   assign o_ovf   = ovf_q;

endmodule

// File: tb/tb_pes_pipe_adder.sv
// tb/tb_pes_pipe_adder.sv - directed and random self-checking bench for pes_pipe_adder
`timescale 1ns/1ps

module tb_pes_pipe_adder;

   logic        i_clk = 1'b0;
   logic        i_rst_n;
   logic        i_valid;
   logic        o_ready;
   logic [15:0] i_a;
   logic [15:0] i_b;
   logic        i_cin;
   logic        i_mode;
   logic        o_valid;
   logic        i_ready;
   logic [15:0] o_sum;
   logic        o_carry;
   logic        o_ovf;

   int errors = 0;
   int checks = 0;

   always #5 i_clk = ~i_clk;

   pes_pipe_adder #(
      .WIDTH  (16),
      .STAGES (4)
   ) dut (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_valid (i_valid),
      .o_ready (o_ready),
      .i_a     (i_a),
      .i_b     (i_b),
      .i_cin   (i_cin),
      .i_mode  (i_mode),
      .o_valid (o_valid),
      .i_ready (i_ready),
      .o_sum   (o_sum),
      .o_carry (o_carry),
      .o_ovf   (o_ovf)
   );

   task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   // Reference: {ovf, carry, sum}
   function automatic logic [17:0] model(input logic m, input logic [15:0] a,
                                         input logic [15:0] b, input logic c);
      logic [15:0] be;
      logic        ce;
      logic [16:0] r;
      be = m ? ~b : b;
      ce = m ? 1'b1 : c;
      r  = {1'b0, a} + {1'b0, be} + {16'd0, ce};
      return {(a[15] == be[15]) && (r[15] != a[15]), r};
   endfunction

   // One isolated operation with i_ready held high; checks exact latency.
   task automatic run_op(input string tag, input logic m, input logic [15:0] a,
                         input logic [15:0] b, input logic c, input logic [15:0] es,
                         input logic ec, input logic eo);
      @(negedge i_clk);
      i_ready = 1'b1;
      i_valid = 1'b1;
      i_mode  = m;
      i_a     = a;
      i_b     = b;
      i_cin   = c;
      #1 chk({tag, "_ready"}, 32'(o_ready), 32'd1);
      @(negedge i_clk);
      i_valid = 1'b0;
      i_a     = 16'($urandom);
      i_b     = 16'($urandom);
      chk({tag, "_lat1"}, 32'(o_valid), 32'd0);
      @(negedge i_clk);
      @(negedge i_clk);
      chk({tag, "_lat3"}, 32'(o_valid), 32'd0);
      @(negedge i_clk);
      chk({tag, "_valid"}, 32'(o_valid), 32'd1);
      chk({tag, "_sum"}, 32'(o_sum), 32'(es));
      chk({tag, "_carry"}, 32'(o_carry), 32'(ec));
      chk({tag, "_ovf"}, 32'(o_ovf), 32'(eo));
   endtask

   logic [17:0] expq[$];
   int          next_n;
   int          recvd;
   int          sent;
   int          stall_seen;
   logic        started;

   initial begin
      i_rst_n = 1'b0;
      i_valid = 1'b0;
      i_ready = 1'b1;
      i_a     = '0;
      i_b     = '0;
      i_cin   = 1'b0;
      i_mode  = 1'b0;
      repeat (2) @(posedge i_clk);
      @(negedge i_clk);
      chk("rst_valid", 32'(o_valid), 32'd0);
      chk("rst_sum", 32'(o_sum), 32'd0);
      chk("rst_carry", 32'(o_carry), 32'd0);
      chk("rst_ovf", 32'(o_ovf), 32'd0);
      chk("rst_ready", 32'(o_ready), 32'd1);
      i_rst_n = 1'b1;

      // Directed vectors
      run_op("add_wrap", 1'b0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
      run_op("sub_neg", 1'b1, 16'h0005, 16'h0007, 1'b0, 16'hFFFE, 1'b0, 1'b0);
      run_op("sub_pos", 1'b1, 16'h0007, 16'h0005, 1'b1, 16'h0002, 1'b1, 1'b0);
      run_op("add_ovf", 1'b0, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
      run_op("sub_ovf", 1'b1, 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b1, 1'b1);
      run_op("add_cin", 1'b0, 16'h00FF, 16'h0000, 1'b1, 16'h0100, 1'b0, 1'b0);

      // Back-pressure: 8 back-to-back ops, consumer stalls on cycles 5..7
      expq.delete();
      next_n     = 1;
      recvd      = 0;
      stall_seen = 0;
      started    = 1'b0;
      for (int c = 0; c < 40 && recvd < 8; c++) begin
         @(negedge i_clk);
         i_ready = !(c >= 5 && c <= 7);
         i_valid = (next_n <= 8);
         i_mode  = 1'b0;
         i_cin   = 1'b0;
         i_a     = 16'(next_n);
         i_b     = 16'(next_n);
         #1;
         if (!i_ready && o_valid) begin
            chk("bp_stall_ready", 32'(o_ready), 32'd0);
            stall_seen++;
         end
         if (started && recvd < 8)
            chk("bp_throughput", 32'(o_valid), 32'd1);
         if (o_valid && i_ready) begin
            if (expq.size() == 0)
               chk("bp_extra", 32'(o_valid), 32'd0);
            else
               chk("bp_result", {14'd0, o_ovf, o_carry, o_sum}, 32'(expq.pop_front()));
            recvd++;
            started = 1'b1;
         end
         if (i_valid && o_ready) begin
            expq.push_back(model(1'b0, 16'(next_n), 16'(next_n), 1'b0));
            next_n++;
         end
      end
      chk("bp_count", 32'(recvd), 32'd8);
      chk("bp_stalls", 32'(stall_seen), 32'd3);
      i_valid = 1'b0;
      i_ready = 1'b1;
      repeat (2) @(negedge i_clk);
      chk("bp_drained", 32'(o_valid), 32'd0);

      // Reset with three operations in flight
      i_ready = 1'b0;
      @(negedge i_clk);
      i_valid = 1'b1; i_mode = 1'b1; i_a = 16'h8000; i_b = 16'h0001; i_cin = 1'b0;
      @(negedge i_clk);
      i_mode = 1'b0; i_a = 16'h0101; i_b = 16'h0202;
      @(negedge i_clk);
      i_a = 16'h0303; i_b = 16'h0404;
      @(negedge i_clk);
      i_valid = 1'b0;
      @(negedge i_clk);
      chk("mid_pre_valid", 32'(o_valid), 32'd1);
      chk("mid_pre_sum", {14'd0, o_ovf, o_carry, o_sum}, 32'h37FFF);
      #2 i_rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", 32'(o_valid), 32'd0);
      chk("mid_rst_sum", 32'(o_sum), 32'd0);
      chk("mid_rst_carry", 32'(o_carry), 32'd0);
      chk("mid_rst_ovf", 32'(o_ovf), 32'd0);
      repeat (2) @(negedge i_clk);
      i_rst_n = 1'b1;
      i_ready = 1'b1;
      #1 chk("mid_rel_ready", 32'(o_ready), 32'd1);
      for (int c = 0; c < 6; c++) begin
         @(negedge i_clk);
         chk("mid_no_stale", 32'(o_valid), 32'd0);
      end
      run_op("mid_new", 1'b0, 16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0, 1'b0);

      // Random regression
      expq.delete();
      sent  = 0;
      recvd = 0;
      for (int c = 0; c < 20000 && recvd < 1000; c++) begin
         @(negedge i_clk);
         i_ready = ($urandom_range(0, 3) != 0);
         i_valid = (sent < 1000) && ($urandom_range(0, 3) != 0);
         i_a     = 16'($urandom);
         i_b     = 16'($urandom);
         i_mode  = 1'($urandom);
         i_cin   = 1'($urandom);
         #1;
         if (o_valid && i_ready) begin
            if (expq.size() == 0)
               chk("rand_extra", 32'(o_valid), 32'd0);
            else
               chk("rand_result", {14'd0, o_ovf, o_carry, o_sum}, 32'(expq.pop_front()));
            recvd++;
         end
         if (i_valid && o_ready) begin
            expq.push_back(model(i_mode, i_a, i_b, i_cin));
            sent++;
         end
      end
      chk("rand_count", 32'(recvd), 32'd1000);
      i_valid = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
